// File: rtl/operand_gen_bypass.sv
// operand_gen_bypass
// ID-stage operand generator with EX/MEM result bypassing and load-use
// stall detection. Both ALU operands are formed from a select code,
// regfile data, the immediate and the link address (PC + 8). They are
// then registered into the ID/EX boundary behind a valid/ready handshake.
//
// Configuration macro: OPGEN_MEM_BYPASS_EN
//   defined   -> MEM-stage results are forwarded to the operands.
//   undefined -> no MEM forwarding. A used source that matches a MEM
//                producer stalls until the regfile write has landed.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   id_valid / id_ready        decoded instruction handshake
//   addr, imm                  instruction PC and raw 16-bit immediate
//   sel_1, sel_2               operand source select codes
//   rs_addr_1/2, reg_data_1/2  source register indices and regfile data
//   ex_wen, ex_is_load, ex_waddr, ex_wdata   EX-stage producer
//   mem_wen, mem_waddr, mem_wdata            MEM-stage producer
//   ex_ready                   EX consumes the registered operands
//   flush                      kill ID/EX contents and the current input
//   out_valid, operand_1/2     registered operands
//   load_stall                 combinational load-use stall indicator
//   stall_count                saturating count of load_stall cycles
module operand_gen_bypass #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [15:0]               imm,
    input  logic [1:0]                sel_1,
    input  logic [2:0]                sel_2,
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr_1,
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr_2,
    input  logic [DATA_WIDTH-1:0]     reg_data_1,
    input  logic [DATA_WIDTH-1:0]     reg_data_2,
    input  logic                      ex_wen,
    input  logic                      ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] ex_waddr,
    input  logic [DATA_WIDTH-1:0]     ex_wdata,
    input  logic                      mem_wen,
    input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      ex_ready,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     operand_1,
    output logic [DATA_WIDTH-1:0]     operand_2,
    output logic                      load_stall,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    // Per-operand views so both source paths come from one generate loop.
    logic [REG_ADDR_WIDTH-1:0] rs_addr  [2];
    logic [DATA_WIDTH-1:0]     reg_data [2];
    logic [DATA_WIDTH-1:0]     src_data [2];
    logic                      src_wait [2];
    logic [1:0]                src_used;

    assign rs_addr[0]  = rs_addr_1;
    assign rs_addr[1]  = rs_addr_2;
    assign reg_data[0] = reg_data_1;
    assign reg_data[1] = reg_data_2;
    assign src_used    = {sel_2 == 3'd1, sel_1 == 2'd1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic nonzero;
            logic ex_hit;
            logic mem_hit;

            assign nonzero = |rs_addr[gi];
            assign ex_hit  = ex_wen && (ex_waddr == rs_addr[gi]);
            assign mem_hit = mem_wen && (mem_waddr == rs_addr[gi]);

`ifdef OPGEN_MEM_BYPASS_EN
            assign src_data[gi] = !nonzero                ? reg_data[gi] :
                                  (ex_hit && !ex_is_load) ? ex_wdata     :
                                  mem_hit                 ? mem_wdata    :
                                                            reg_data[gi];
            assign src_wait[gi] = nonzero && ex_hit && ex_is_load;
`else
            assign src_data[gi] = (nonzero && ex_hit && !ex_is_load) ? ex_wdata
                                                                     : reg_data[gi];
            // An EX match shadows any older MEM value, so a MEM match only
            // has to wait when EX does not own the register.
            assign src_wait[gi] = nonzero && (ex_hit ? ex_is_load : mem_hit);
`endif
        end
    endgenerate

`ifndef OPGEN_MEM_BYPASS_EN
    logic unused_mem_wdata;
    assign unused_mem_wdata = ^mem_wdata;
`endif

    logic hazard;
    assign hazard     = id_valid && ((src_used[0] && src_wait[0]) ||
                                     (src_used[1] && src_wait[1]));
    assign load_stall = hazard;

    // Link address wraps within the PC width, then zero-extends.
    logic [ADDR_WIDTH-1:0] link_addr;
    logic [DATA_WIDTH-1:0] link_data;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_zext;
    logic [DATA_WIDTH-1:0] imm_high;

    assign link_addr = addr + ADDR_WIDTH'(8);
    assign link_data = DATA_WIDTH'(link_addr);
    assign imm_sext  = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign imm_zext  = {{(DATA_WIDTH-16){1'b0}}, imm};
    assign imm_high  = DATA_WIDTH'({imm, 16'h0000});

    logic [DATA_WIDTH-1:0] op1_mux;
    logic [DATA_WIDTH-1:0] op2_mux;

    always_comb begin
        op1_mux = '0;
        case (sel_1)
            2'd1:    op1_mux = src_data[0];
            2'd2:    op1_mux = link_data;
            default: op1_mux = '0;
        endcase
    end

    always_comb begin
        op2_mux = '0;
        case (sel_2)
            3'd1:    op2_mux = src_data[1];
            3'd2:    op2_mux = imm_sext;
            3'd3:    op2_mux = imm_zext;
            3'd4:    op2_mux = imm_high;
            default: op2_mux = '0;
        endcase
    end

    logic                  out_valid_reg,   out_valid_next;
    logic [DATA_WIDTH-1:0] operand_1_reg,   operand_1_next;
    logic [DATA_WIDTH-1:0] operand_2_reg,   operand_2_next;
    logic [CNT_WIDTH-1:0]  stall_count_reg, stall_count_next;

    assign id_ready = !hazard && (!out_valid_reg || ex_ready);

    always_comb begin
        out_valid_next   = out_valid_reg;
        operand_1_next   = operand_1_reg;
        operand_2_next   = operand_2_reg;
        stall_count_next = stall_count_reg;

        if (hazard && (stall_count_reg != '1)) begin
            stall_count_next = stall_count_reg + CNT_WIDTH'(1);
        end

        if (flush) begin
            out_valid_next = 1'b0;
        end else if (out_valid_reg && !ex_ready) begin
            // Backpressure: hold everything, even when a hazard is present.
        end else if (id_valid && id_ready) begin
            out_valid_next = 1'b1;
            operand_1_next = op1_mux;
            operand_2_next = op2_mux;
        end else begin
            // Bubble: operands keep their stale values behind out_valid=0.
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            operand_1_reg   <= '0;
            operand_2_reg   <= '0;
            stall_count_reg <= '0;
        end else begin
            out_valid_reg   <= out_valid_next;
            operand_1_reg   <= operand_1_next;
            operand_2_reg   <= operand_2_next;
            stall_count_reg <= stall_count_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign operand_1   = operand_1_reg;
    assign operand_2   = operand_2_reg;
    assign stall_count = stall_count_reg;

endmodule
